// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: AXI4-Lite read master feeding a prefetch FIFO.
// Optional FETCH_STOP_ON_ERR_EN: stop issuing after an error response.
module fetch_prefetch_unit #(
  parameter int XLEN            = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            jump_taken,
  input  logic [XLEN-1:0] jump_addr,
  output logic [XLEN-1:0] imem_axi_araddr,
  output logic [2:0]      imem_axi_arprot,
  output logic            imem_axi_arvalid,
  input  logic            imem_axi_arready,
  input  logic [XLEN-1:0] imem_axi_rdata,
  input  logic [1:0]      imem_axi_rresp,
  input  logic            imem_axi_rvalid,
  output logic            imem_axi_rready,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [XLEN-1:0] PC_IF,
  output logic [XLEN-1:0] IR_IF,
  output logic [1:0]      imem_axi_rresp_IF
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] MAX_C = (CW+1)'(MAX_OUTSTANDING);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0] resp_pc, resp_pc_nxt;
  logic [XLEN-1:0] araddr_q, araddr_nxt;
  logic            arvalid_q, arvalid_nxt;
  logic            stale, stale_nxt;
  logic [CW-1:0]   inflight, inflight_nxt;
  logic [CW-1:0]   discard, discard_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            ar_hs, accept, pop, hold_ar;
  logic            issue_ok, err_stop_nxt, full;

  logic [XLEN-1:0] pc_mem [FIFO_DEPTH];
  logic [XLEN-1:0] ir_mem [FIFO_DEPTH];
  logic [1:0]      rs_mem [FIFO_DEPTH];

`ifdef FETCH_STOP_ON_ERR_EN
  logic err_stop;

  // Sticky error stop, cleared by a redirect.
  always_ff @(posedge clk) begin
    if (reset) err_stop <= 1'b0;
    else       err_stop <= err_stop_nxt;
  end
`endif

  // Credit bookkeeping, redirect handling and AR channel next state.
  always_comb begin
    ar_hs   = arvalid_q && imem_axi_arready;
    hold_ar = arvalid_q && !imem_axi_arready;
    accept  = imem_axi_rvalid && (discard == '0) && !jump_taken;
    pop     = valid_out && ready_in && !jump_taken;

    inflight_nxt = inflight + CW'(ar_hs) - CW'(imem_axi_rvalid);

    if (jump_taken) cnt_nxt = '0;
    else            cnt_nxt = cnt + CW'(accept) - CW'(pop);

    discard_nxt = discard;
    if (imem_axi_rvalid && discard != '0)
      discard_nxt = discard - CW'(1);
    // A stale AR held across a redirect becomes garbage once accepted.
    if (stale && ar_hs)
      discard_nxt = discard_nxt + CW'(1);
    if (jump_taken)
      discard_nxt = inflight_nxt;

    if (jump_taken) stale_nxt = hold_ar;
    else            stale_nxt = stale && !ar_hs;

    if (jump_taken)          fetch_pc_nxt = jump_addr;
    else if (ar_hs && !stale) fetch_pc_nxt = fetch_pc + XLEN'(4);
    else                     fetch_pc_nxt = fetch_pc;

    if (jump_taken)  resp_pc_nxt = jump_addr;
    else if (accept) resp_pc_nxt = resp_pc + XLEN'(4);
    else             resp_pc_nxt = resp_pc;

`ifdef FETCH_STOP_ON_ERR_EN
    if (jump_taken) err_stop_nxt = 1'b0;
    else err_stop_nxt = err_stop || (accept && imem_axi_rresp != 2'b00);
`else
    err_stop_nxt = 1'b0;
`endif

    issue_ok = ({1'b0, inflight_nxt} < MAX_C)
            && (({1'b0, inflight_nxt} + {1'b0, cnt_nxt}) < DEPTH_C)
            && !err_stop_nxt;

    arvalid_nxt = hold_ar ? 1'b1 : issue_ok;
    araddr_nxt  = hold_ar ? araddr_q : fetch_pc_nxt;
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_VEC;
      resp_pc   <= RESET_VEC;
      araddr_q  <= RESET_VEC;
      arvalid_q <= 1'b0;
      stale     <= 1'b0;
      inflight  <= '0;
      discard   <= '0;
      cnt       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      fetch_pc  <= fetch_pc_nxt;
      resp_pc   <= resp_pc_nxt;
      araddr_q  <= araddr_nxt;
      arvalid_q <= arvalid_nxt;
      stale     <= stale_nxt;
      inflight  <= inflight_nxt;
      discard   <= discard_nxt;
      cnt       <= cnt_nxt;
      if (jump_taken) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + AW'(1);
        if (pop)    rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // FIFO storage; contents only matter while counted valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_mem[wr_ptr] <= resp_pc;
      ir_mem[wr_ptr] <= imem_axi_rdata;
      rs_mem[wr_ptr] <= imem_axi_rresp;
    end
  end

  assign full              = ({1'b0, cnt} == DEPTH_C);
  assign valid_out         = (cnt != '0);
  assign PC_IF             = valid_out ? pc_mem[rd_ptr] : '0;
  assign IR_IF             = valid_out ? ir_mem[rd_ptr] : '0;
  assign imem_axi_rresp_IF = valid_out ? rs_mem[rd_ptr] : 2'b00;
  assign imem_axi_araddr   = araddr_q;
  assign imem_axi_arvalid  = arvalid_q;
  assign imem_axi_arprot   = 3'b100;
  assign imem_axi_rready   = 1'b1;

  // Credits must make an accepted response into a full FIFO impossible.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset) !(accept && full));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a simple in-order AXI slave.
// Expected values are hand-derived per scenario.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        jump_taken;
  logic [31:0] jump_addr;
  logic [31:0] imem_axi_araddr;
  logic [2:0]  imem_axi_arprot;
  logic        imem_axi_arvalid;
  logic        imem_axi_arready;
  logic [31:0] imem_axi_rdata;
  logic [1:0]  imem_axi_rresp;
  logic        imem_axi_rvalid;
  logic        imem_axi_rready;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] PC_IF;
  logic [31:0] IR_IF;
  logic [1:0]  imem_axi_rresp_IF;

  int checks = 0;
  int errors = 0;

  logic        r_hold;
  logic        err_on;
  logic [31:0] err_addr;
  logic [31:0] pend[$];
  logic [31:0] ar_log[$];
  logic [31:0] del_pc[$];
  logic [31:0] del_ir[$];
  logic [1:0]  del_rs[$];
  int          rbeats;

  fetch_prefetch_unit #(
    .XLEN(32), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2),
    .RESET_VEC(32'h100)
  ) dut (
    .clk(clk), .reset(reset),
    .jump_taken(jump_taken), .jump_addr(jump_addr),
    .imem_axi_araddr(imem_axi_araddr),
    .imem_axi_arprot(imem_axi_arprot),
    .imem_axi_arvalid(imem_axi_arvalid),
    .imem_axi_arready(imem_axi_arready),
    .imem_axi_rdata(imem_axi_rdata),
    .imem_axi_rresp(imem_axi_rresp),
    .imem_axi_rvalid(imem_axi_rvalid),
    .imem_axi_rready(imem_axi_rready),
    .valid_out(valid_out), .ready_in(ready_in),
    .PC_IF(PC_IF), .IR_IF(IR_IF),
    .imem_axi_rresp_IF(imem_axi_rresp_IF)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Sample handshakes and deliveries away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        pend.delete();
      end else begin
        if (imem_axi_arvalid && imem_axi_arready) begin
          pend.push_back(imem_axi_araddr);
          ar_log.push_back(imem_axi_araddr);
        end
        if (imem_axi_rvalid) rbeats++;
        if (valid_out && ready_in && !jump_taken) begin
          del_pc.push_back(PC_IF);
          del_ir.push_back(IR_IF);
          del_rs.push_back(imem_axi_rresp_IF);
        end
      end
    end
  end

  // Slave R channel: one beat per cycle, one cycle after AR.
  initial begin
    logic [31:0] a;
    imem_axi_rvalid = 1'b0;
    imem_axi_rdata  = '0;
    imem_axi_rresp  = 2'b00;
    forever begin
      @(posedge clk);
      #2;
      if (reset || r_hold || pend.size() == 0) begin
        imem_axi_rvalid = 1'b0;
      end else begin
        a = pend.pop_front();
        imem_axi_rvalid = 1'b1;
        imem_axi_rdata  = mem_word(a);
        imem_axi_rresp  = (err_on && a == err_addr) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    jump_taken = 1'b0;
    jump_addr = '0;
    imem_axi_arready = 1'b1;
    ready_in = 1'b1;
    r_hold = 1'b0;
    err_on = 1'b0;
    err_addr = '0;
    tick(2);
    ar_log.delete();
    del_pc.delete();
    del_ir.delete();
    del_rs.delete();
    rbeats = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (imem_axi_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_arvalid: got %b want 0", imem_axi_arvalid);
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_out: got %b want 0", valid_out);
    end
    checks++;
    if (imem_axi_araddr !== 32'h100) begin
      errors++;
      $display("FAIL reset_araddr: got %h want 100", imem_axi_araddr);
    end
    checks++;
    if (PC_IF !== 32'h0 || IR_IF !== 32'h0) begin
      errors++;
      $display("FAIL reset_head: got %h/%h want 0/0", PC_IF, IR_IF);
    end
    checks++;
    if (imem_axi_arprot !== 3'b100 || imem_axi_rready !== 1'b1) begin
      errors++;
      $display("FAIL const_outs: got %b/%b want 100/1",
               imem_axi_arprot, imem_axi_rready);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    reset = 1'b0;
    tick(1);
    checks++;
    if (imem_axi_arvalid !== 1'b1 || imem_axi_araddr !== 32'h100) begin
      errors++;
      $display("FAIL seq_first_ar: got %b/%h want 1/100",
               imem_axi_arvalid, imem_axi_araddr);
    end
    tick(1);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL seq_early_valid: got %b want 0", valid_out);
    end
    tick(1);
    checks++;
    if (valid_out !== 1'b1 || PC_IF !== 32'h100 ||
        IR_IF !== mem_word(32'h100)) begin
      errors++;
      $display("FAIL seq_latency: got %b/%h/%h want 1/100/%h",
               valid_out, PC_IF, IR_IF, mem_word(32'h100));
    end
    tick(10);
    checks++;
    if (ar_log.size() < 3 || del_pc.size() < 3) begin
      errors++;
      $display("FAIL seq_count: got ar %0d del %0d want >=3",
               ar_log.size(), del_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        logic [31:0] e;
        e = 32'h100 + 32'(4 * i);
        checks++;
        if (ar_log[i] !== e || del_pc[i] !== e ||
            del_ir[i] !== mem_word(e)) begin
          errors++;
          $display("FAIL seq_entry%0d: got ar %h pc %h ir %h want %h/%h",
                   i, ar_log[i], del_pc[i], del_ir[i], e, mem_word(e));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_in = 1'b0;
    reset = 1'b0;
    tick(20);
    checks++;
    if (ar_log.size() != 4) begin
      errors++;
      $display("FAIL bp_ar_count: got %0d want 4", ar_log.size());
    end
    checks++;
    if (valid_out !== 1'b1 || PC_IF !== 32'h100) begin
      errors++;
      $display("FAIL bp_head: got %b/%h want 1/100", valid_out, PC_IF);
    end
    checks++;
    if (rbeats != 4 || imem_axi_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_beats: got %0d/%b want 4/0",
               rbeats, imem_axi_arvalid);
    end
    ready_in = 1'b1;
    tick(20);
    checks++;
    if (del_pc.size() < 8) begin
      errors++;
      $display("FAIL bp_drain: got %0d want >=8", del_pc.size());
    end
    for (int i = 0; i < del_pc.size(); i++) begin
      checks++;
      if (del_pc[i] !== 32'h100 + 32'(4 * i)) begin
        errors++;
        $display("FAIL bp_order%0d: got %h want %h",
                 i, del_pc[i], 32'h100 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_jump_inflight();
    do_reset();
    r_hold = 1'b1;
    reset = 1'b0;
    tick(5);
    checks++;
    if (ar_log.size() != 2 || imem_axi_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL jf_setup: got %0d/%b want 2/0",
               ar_log.size(), imem_axi_arvalid);
    end
    jump_taken = 1'b1;
    jump_addr = 32'h200;
    tick(1);
    jump_taken = 1'b0;
    r_hold = 1'b0;
    tick(15);
    checks++;
    if (del_pc.size() < 1 || del_pc[0] !== 32'h200 ||
        del_ir[0] !== mem_word(32'h200)) begin
      errors++;
      $display("FAIL jf_first: got n=%0d want pc 200",
               del_pc.size());
    end
    checks++;
    if (ar_log.size() < 3 || ar_log[2] !== 32'h200) begin
      errors++;
      $display("FAIL jf_ar: got n=%0d want third ar 200",
               ar_log.size());
    end
    for (int i = 0; i < del_pc.size(); i++) begin
      checks++;
      if (del_pc[i] === 32'h100 || del_pc[i] === 32'h104) begin
        errors++;
        $display("FAIL jf_stale%0d: got %h want not 100/104",
                 i, del_pc[i]);
      end
    end
  endtask

  task automatic test_jump_stalled_ar();
    do_reset();
    reset = 1'b0;
    tick(2);
    imem_axi_arready = 1'b0;
    tick(1);
    checks++;
    if (imem_axi_arvalid !== 1'b1 || imem_axi_araddr !== 32'h104) begin
      errors++;
      $display("FAIL js_pre: got %b/%h want 1/104",
               imem_axi_arvalid, imem_axi_araddr);
    end
    tick(1);
    jump_taken = 1'b1;
    jump_addr = 32'h300;
    tick(1);
    jump_taken = 1'b0;
    checks++;
    if (imem_axi_arvalid !== 1'b1 || imem_axi_araddr !== 32'h104) begin
      errors++;
      $display("FAIL js_hold: got %b/%h want 1/104",
               imem_axi_arvalid, imem_axi_araddr);
    end
    tick(3);
    checks++;
    if (imem_axi_arvalid !== 1'b1 || imem_axi_araddr !== 32'h104) begin
      errors++;
      $display("FAIL js_hold2: got %b/%h want 1/104",
               imem_axi_arvalid, imem_axi_araddr);
    end
    imem_axi_arready = 1'b1;
    tick(1);
    checks++;
    if (imem_axi_arvalid !== 1'b1 || imem_axi_araddr !== 32'h300) begin
      errors++;
      $display("FAIL js_new: got %b/%h want 1/300",
               imem_axi_arvalid, imem_axi_araddr);
    end
    tick(10);
    checks++;
    if (del_pc.size() < 2 || del_pc[0] !== 32'h100 ||
        del_pc[1] !== 32'h300) begin
      errors++;
      $display("FAIL js_order: got n=%0d want 100,300",
               del_pc.size());
    end
    for (int i = 0; i < del_pc.size(); i++) begin
      checks++;
      if (del_pc[i] === 32'h104) begin
        errors++;
        $display("FAIL js_stale%0d: got %h want not 104", i, del_pc[i]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    reset = 1'b0;
    jump_taken = 1'b1;
    jump_addr = 32'hFFFF_FFFC;
    tick(1);
    jump_taken = 1'b0;
    checks++;
    if (imem_axi_arvalid !== 1'b1 || imem_axi_araddr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_ar0: got %b/%h want 1/fffffffc",
               imem_axi_arvalid, imem_axi_araddr);
    end
    tick(1);
    checks++;
    if (imem_axi_araddr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_ar1: got %h want 0", imem_axi_araddr);
    end
    tick(10);
    checks++;
    if (del_pc.size() < 2 || del_pc[0] !== 32'hFFFF_FFFC ||
        del_pc[1] !== 32'h0 || del_ir[1] !== mem_word(32'h0)) begin
      errors++;
      $display("FAIL wrap_del: got n=%0d want fffffffc,0",
               del_pc.size());
    end
  endtask

  task automatic test_error_resp();
    do_reset();
    err_on = 1'b1;
    err_addr = 32'h108;
    reset = 1'b0;
    tick(20);
    checks++;
    if (del_pc.size() < 4) begin
      errors++;
      $display("FAIL err_count: got %0d want >=4", del_pc.size());
    end else begin
      checks++;
      if (del_pc[2] !== 32'h108 || del_rs[2] !== 2'b10) begin
        errors++;
        $display("FAIL err_entry: got %h/%0d want 108/2",
                 del_pc[2], del_rs[2]);
      end
      checks++;
      if (del_rs[1] !== 2'b00 || del_pc[3] !== 32'h10C ||
          del_rs[3] !== 2'b00) begin
        errors++;
        $display("FAIL err_neighbours: got %0d/%h/%0d want 0/10c/0",
                 del_rs[1], del_pc[3], del_rs[3]);
      end
    end
`ifdef FETCH_STOP_ON_ERR_EN
    checks++;
    if (ar_log.size() != 4) begin
      errors++;
      $display("FAIL err_stop: got %0d ars want 4", ar_log.size());
    end
`else
    checks++;
    if (ar_log.size() <= 4) begin
      errors++;
      $display("FAIL err_continue: got %0d ars want >4", ar_log.size());
    end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    r_hold = 1'b1;
    reset = 1'b0;
    tick(5);
    jump_taken = 1'b1;
    jump_addr = 32'h200;
    tick(1);
    jump_addr = 32'h400;
    tick(1);
    jump_taken = 1'b0;
    r_hold = 1'b0;
    tick(15);
    checks++;
    if (del_pc.size() < 2 || del_pc[0] !== 32'h400 ||
        del_pc[1] !== 32'h404) begin
      errors++;
      $display("FAIL b2b_del: got n=%0d want 400,404", del_pc.size());
    end
    checks++;
    if (ar_log.size() < 3 || ar_log[2] !== 32'h400) begin
      errors++;
      $display("FAIL b2b_ar: got n=%0d want third ar 400",
               ar_log.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    jump_taken = 1'b0;
    jump_addr = '0;
    imem_axi_arready = 1'b1;
    ready_in = 1'b1;
    r_hold = 1'b0;
    err_on = 1'b0;
    err_addr = '0;
    rbeats = 0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_jump_inflight();
    test_jump_stalled_ar();
    test_wrap();
    test_error_resp();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
